wait_phase_gen: RTL and testbench
=================================

// Module: wait_phase_gen
// PURPOSE
//  Synthesizable, clock-qualified version of a wait-driven two-phase stimulus process.
//  On a start request it drives alternating A/B phases with programmable per-phase
//  durations. It also drives G0/G1 gate flags and reports busy/done/round status.
//  It sits directly upstream of the wait-statement test block and feeds that block's
//  A, B, G0 and G1 signals. All sequencing is cycle-counted; there are no # delays.
// PARAMETERS
//  DW          8   width of the phase-duration inputs and down-counter
//  RW          16  width of the completed-round counter (wraps at 2**RW)
//  GAP_CYCLES  2   dead-time length in cycles (used only with WPG_GAP_EN)
// PORTS
//  clk      in   1   single clock, all logic on rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   level request; sampled in IDLE only
//  repeat   in   1   at end of phase B: 1 = loop to phase A, 0 = finish
//  abort    in   1   force return to IDLE from any state, no done pulse
//  dly_a    in   DW  phase-A length in cycles (0 treated as 1)
//  dly_b    in   DW  phase-B length in cycles (0 treated as 1)
//  A        out  1   phase-A output, registered
//  B        out  1   phase-B output, registered
//  G0       out  1   gate flag: 1 while idle, 0 while sequencing
//  G1       out  1   always ~G0
//  busy     out  1   1 in every state except IDLE
//  done     out  1   one-cycle pulse on normal completion
//  rounds   out  RW  count of completed A+B pairs since reset
// BEHAVIOUR
//  - Reset values: A=0, B=0, G0=1, G1=0, busy=0, done=0, rounds=0. FSM goes to IDLE.
//  - Reset wins over every other input in the same cycle, including mid-phase.
//  - States: IDLE, PH_A, PH_B, FIN (plus GAP with WPG_GAP_EN).
//  - IDLE, start=1 at edge t:
//      dly_a and dly_b are latched into internal regs.
//      From t+1: A=1, B=0, G0=0, G1=1, busy=1. State is PH_A.
//  - dly_a/dly_b changes after the latch edge are ignored until the next start.
//  - PH_A lasts exactly max(dly_a,1) cycles, then PH_B.
//  - PH_B: A=0, B=1, lasts exactly max(dly_b,1) cycles.
//  - End of PH_B:
//      rounds increments by 1 (wraps).
//      repeat=1 -> PH_A. The latched durations are reused; start is not re-sampled.
//      repeat=0 -> FIN.
//  - FIN, one cycle: A=0, B=0, done=1, busy=1. Next cycle: IDLE, G0=1, G1=0, busy=0.
//  - start is ignored while busy.
//  - start held high through FIN -> new sequence begins the cycle after IDLE is re-entered.
//  - IDLE is never skipped.
//  - abort=1 in any non-IDLE state -> IDLE next cycle. A=B=0, no done pulse.
//    rounds is not incremented for a partial pair.
//  - abort coincident with the end of a phase: abort wins, and that pair is not counted.
//  - abort in IDLE has no effect. abort and start together in IDLE: abort wins, stays IDLE.
//  - A and B are never 1 in the same cycle.
//  - Down-counter is DW bits and loaded with len-1; no arithmetic overflow is possible.
// CONFIGURATION
//  WPG_GAP_EN defined:
//    A GAP state of GAP_CYCLES cycles (A=B=0, busy=1) is inserted on PH_A->PH_B
//    and PH_B->PH_A transitions. No gap on PH_B->FIN.
//    abort applies during GAP.
//  WPG_GAP_EN undefined:
//    No GAP state. A falls on the same edge B rises (and vice versa).
// TESTING
//  1. rst=1 for 2 cycles -> A=0, B=0, G0=1, G1=0, busy=0, done=0, rounds=0.
//  2. dly_a=3, dly_b=2, repeat=0, start pulse ->
//     A high cycles 1-3, B high cycles 4-5, done=1 cycle 6, rounds=1, idle cycle 7.
//  3. dly_a=0, dly_b=0 -> A and B each high exactly 1 cycle; done follows.
//  4. repeat=1 for 3 pairs, dly_a=2, dly_b=2, then repeat=0 -> rounds=3, single done pulse.
//     With WPG_GAP_EN and GAP_CYCLES=2: A=B=0 for 2 cycles at each A/B boundary.
//  5. abort on the final cycle of PH_B -> IDLE next cycle, no done, rounds unchanged.
//  6. rst asserted mid-PH_A -> all outputs at reset values next cycle.
//     Assert A&B never 1 together in all runs.

Source files
------------

// File: rtl/wait_phase_gen.sv
// -----------------------------------------------------------------------------
// wait_phase_gen
//
// Cycle-counted two-phase stimulus generator. A start request in IDLE latches
// the two phase durations and then drives alternating A/B phases. At the end of
// each B phase one completed pair is counted, and the sequence either loops back
// to A or finishes with a one-cycle done pulse. This block feeds the A, B, G0
// and G1 inputs of the wait-statement test block that sits downstream.
//
// Optional feature (compile-time macro WPG_GAP_EN):
//   defined   -> a GAP state of GAP_CYCLES cycles (A=B=0, busy=1) separates
//                PH_A->PH_B and PH_B->PH_A. There is no gap on PH_B->FIN.
//   undefined -> no GAP state. A falls on the same edge that B rises, and
//                B falls on the same edge that A rises.
//
// Parameters
//   DW          width of the phase-duration inputs and the phase down-counter
//   RW          width of the completed-round counter (wraps at 2**RW)
//   GAP_CYCLES  dead-time length in cycles (only used with WPG_GAP_EN, >= 1)
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst        in   1   synchronous reset, active-high, beats every other input
//   start      in   1   level request, sampled in IDLE only
//   repeat_en  in   1   sampled at the end of PH_B: 1 = loop to PH_A, 0 = finish
//                       ("repeat" is a reserved word, hence the suffix)
//   abort      in   1   return to IDLE from any busy state, no done pulse
//   dly_a      in   DW  phase-A length in cycles (0 behaves as 1)
//   dly_b      in   DW  phase-B length in cycles (0 behaves as 1)
//   A          out  1   phase-A output, registered
//   B          out  1   phase-B output, registered
//   G0         out  1   gate flag: 1 while idle, 0 while sequencing
//   G1         out  1   always ~G0
//   busy       out  1   1 in every state except IDLE
//   done       out  1   one-cycle pulse on normal completion
//   rounds     out  RW  completed A+B pairs since reset
// -----------------------------------------------------------------------------
module wait_phase_gen #(
  parameter int DW         = 8,
  parameter int RW         = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          repeat_en,
  input  logic          abort,
  input  logic [DW-1:0] dly_a,
  input  logic [DW-1:0] dly_b,
  output logic          A,
  output logic          B,
  output logic          G0,
  output logic          G1,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rounds
);

  // A zero-length dead time would make the GAP state meaningless.
  if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
    $error("wait_phase_gen: GAP_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH_A,
    S_PH_B,
`ifdef WPG_GAP_EN
    S_GAP,
`endif
    S_FIN
  } state_t;

  state_t        state;
  state_t        state_nxt;

  // Phase down-counter holds (remaining cycles - 1); the phase ends when it
  // reads zero. Loading len-1 keeps a full DW-bit duration representable.
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;

  // Durations captured at start, stored already converted to len-1.
  logic [DW-1:0] len_a;
  logic [DW-1:0] len_b;
  logic          latch_len;

  // Asserted on the edge that closes a PH_B without abort.
  logic          pair_done;

`ifdef WPG_GAP_EN
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_nxt;
  // Remembers which phase the current gap leads into.
  logic          gap_to_b;
  logic          gap_to_b_nxt;
`endif

  // Convert a requested duration to the counter load value, mapping 0 to 1.
  function automatic logic [DW-1:0] len_m1(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
    latch_len = 1'b0;
    pair_done = 1'b0;
`ifdef WPG_GAP_EN
    gcnt_nxt     = (gcnt != '0) ? gcnt - 1'b1 : gcnt;
    gap_to_b_nxt = gap_to_b;
`endif

    unique case (state)
      S_IDLE: begin
        // abort and start together in IDLE: abort wins and IDLE is kept.
        if (start && !abort) begin
          state_nxt = S_PH_A;
          cnt_nxt   = len_m1(dly_a);
          latch_len = 1'b1;
        end
      end

      S_PH_A: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
`ifdef WPG_GAP_EN
          state_nxt    = S_GAP;
          gcnt_nxt     = GAP_LAST;
          gap_to_b_nxt = 1'b1;
`else
          state_nxt = S_PH_B;
          cnt_nxt   = len_b;
`endif
        end
      end

      S_PH_B: begin
        // abort on the last B cycle discards the pair: no count, no done.
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (cnt == '0) begin
          pair_done = 1'b1;
          if (repeat_en) begin
`ifdef WPG_GAP_EN
            state_nxt    = S_GAP;
            gcnt_nxt     = GAP_LAST;
            gap_to_b_nxt = 1'b0;
`else
            state_nxt = S_PH_A;
            cnt_nxt   = len_a;
`endif
          end else begin
            state_nxt = S_FIN;
          end
        end
      end

`ifdef WPG_GAP_EN
      S_GAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (gcnt == '0) begin
          if (gap_to_b) begin
            state_nxt = S_PH_B;
            cnt_nxt   = len_b;
          end else begin
            state_nxt = S_PH_A;
            cnt_nxt   = len_a;
          end
        end
      end
`endif

      // FIN always passes through IDLE, so a start held high here only takes
      // effect one cycle after IDLE is re-entered.
      S_FIN: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the latched durations are reset as well; they are only read after
      // a start reloads them, but a defined value keeps simulation X-free.
      state  <= S_IDLE;
      cnt    <= '0;
      len_a  <= '0;
      len_b  <= '0;
      A      <= 1'b0;
      B      <= 1'b0;
      G0     <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      rounds <= '0;
`ifdef WPG_GAP_EN
      gcnt     <= '0;
      gap_to_b <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch_len) begin
        len_a <= len_m1(dly_a);
        len_b <= len_m1(dly_b);
      end
      if (pair_done) begin
        rounds <= rounds + 1'b1;
      end
      // Outputs are decoded from the next state so they line up with the
      // state register and change on the same edge as the state.
      A    <= (state_nxt == S_PH_A);
      B    <= (state_nxt == S_PH_B);
      G0   <= (state_nxt == S_IDLE);
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_FIN);
`ifdef WPG_GAP_EN
      gcnt     <= gcnt_nxt;
      gap_to_b <= gap_to_b_nxt;
`endif
    end
  end

  assign G1 = ~G0;

endmodule

// File: tb/tb_wait_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_wait_phase_gen
//
// Self-checking bench for wait_phase_gen. For every sequence it first writes
// out the whole expected output trace as a list of cycles (A cycles, optional
// gap, B cycles, repeated per pair, then FIN and IDLE, truncated on abort),
// together with the repeat/abort inputs to apply on each cycle. A compare
// process checks the DUT against the current trace entry on every falling edge.
// Honors WPG_GAP_EN with the default GAP_CYCLES of 2.
// -----------------------------------------------------------------------------
module tb_wait_phase_gen;

`ifdef WPG_GAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        repeat_en;
  logic        abort;
  logic [7:0]  dly_a;
  logic [7:0]  dly_b;
  logic        A;
  logic        B;
  logic        G0;
  logic        G1;
  logic        busy;
  logic        done;
  logic [15:0] rounds;

  wait_phase_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .repeat_en (repeat_en),
    .abort     (abort),
    .dly_a     (dly_a),
    .dly_b     (dly_b),
    .A         (A),
    .B         (B),
    .G0        (G0),
    .G1        (G1),
    .busy      (busy),
    .done      (done),
    .rounds    (rounds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        a;
    logic        b;
    logic        g0;
    logic        busy;
    logic        done;
    logic [15:0] rounds;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t exp_q[$];
  logic rep_q[$];
  logic abt_q[$];

  obs_t        exp_cur;
  logic        chk_en = 1'b0;
  logic [15:0] model_rounds = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, got, want);
    end
  endtask

  function automatic obs_t mk(input logic a, input logic b, input logic g0,
                              input logic bsy, input logic dn, input logic [15:0] r);
    obs_t o;
    o.a = a; o.b = b; o.g0 = g0; o.busy = bsy; o.done = dn; o.rounds = r;
    return o;
  endfunction

  // Layout {A,B,G0,G1,busy,done,rounds[15:0]} in the low 22 bits.
  function automatic logic [31:0] pack_exp(input obs_t o);
    return {10'b0, o.a, o.b, o.g0, ~o.g0, o.busy, o.done, o.rounds};
  endfunction

  function automatic logic [31:0] dut_pack();
    return {10'b0, A, B, G0, G1, busy, done, rounds};
  endfunction

  // Expected trace of one sequence. Entry i is what the outputs must show after
  // the i-th edge following the start edge; rep_q/abt_q[i] are driven during
  // that same cycle. k: -1 no abort, -2 random abort point, >=0 abort index.
  task automatic build(input int la_raw, input int lb_raw, input int np,
                       input int k, input logic [15:0] r0);
    int la;
    int lb;
    logic [15:0] r;
    int kk;
    la = (la_raw == 0) ? 1 : la_raw;
    lb = (lb_raw == 0) ? 1 : lb_raw;
    r  = r0;
    exp_q.delete(); rep_q.delete(); abt_q.delete();
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < la; i++) begin
        exp_q.push_back(mk(1, 0, 0, 1, 0, r)); rep_q.push_back(1'($urandom)); abt_q.push_back(0);
      end
      for (int i = 0; i < GAP; i++) begin
        exp_q.push_back(mk(0, 0, 0, 1, 0, r)); rep_q.push_back(1'($urandom)); abt_q.push_back(0);
      end
      for (int i = 0; i < lb; i++) begin
        exp_q.push_back(mk(0, 1, 0, 1, 0, r));
        rep_q.push_back((i == lb - 1) ? (p < np - 1) : 1'($urandom));
        abt_q.push_back(0);
      end
      r = r + 16'd1;
      if (p < np - 1) begin
        for (int i = 0; i < GAP; i++) begin
          exp_q.push_back(mk(0, 0, 0, 1, 0, r)); rep_q.push_back(1'($urandom)); abt_q.push_back(0);
        end
      end
    end
    exp_q.push_back(mk(0, 0, 0, 1, 1, r)); rep_q.push_back(1'($urandom)); abt_q.push_back(0);
    exp_q.push_back(mk(0, 0, 1, 0, 0, r)); rep_q.push_back(0);              abt_q.push_back(0);

    kk = k;
    if (kk == -2) kk = $urandom_range(0, exp_q.size() - 2);
    if (kk >= 0 && kk < exp_q.size() - 1) begin
      while (exp_q.size() > kk + 1) begin
        void'(exp_q.pop_back()); void'(rep_q.pop_back()); void'(abt_q.pop_back());
      end
      abt_q[kk] = 1'b1;
      exp_q.push_back(mk(0, 0, 1, 0, 0, exp_q[kk].rounds));
      rep_q.push_back(0);
      abt_q.push_back(0);
    end
  endtask

  // Called in an IDLE cycle; leaves the bench in the IDLE cycle that follows.
  task automatic run_txn(input int la, input int lb, input int np, input int k);
    build(la, lb, np, k, model_rounds);
    start = 1'b1; abort = 1'b0;
    dly_a = la[7:0]; dly_b = lb[7:0]; repeat_en = 1'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      exp_cur = exp_q[i];
      if (i < exp_q.size() - 1) begin
        // start and the durations are scrambled while busy; all must be ignored.
        start = 1'($urandom); abort = abt_q[i]; repeat_en = rep_q[i];
        dly_a = 8'($urandom); dly_b = 8'($urandom);
      end else begin
        start = 1'b0; abort = 1'b0;
      end
    end
    model_rounds = exp_q[exp_q.size() - 1].rounds;
  endtask

  // Idle cycles, sometimes with start and abort both high (must stay IDLE).
  task automatic idle_cycles(input int n);
    logic s;
    for (int i = 0; i < n; i++) begin
      s = 1'($urandom);
      start = s; abort = s ? 1'b1 : 1'($urandom);
      @(posedge clk); #1;
      exp_cur = mk(0, 0, 1, 0, 0, model_rounds);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", dut_pack(), pack_exp(exp_cur));
      assert (!(A && B)) else $error("FAIL a_and_b_exclusive at %0t", $time);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; repeat_en = 1'b0; abort = 1'b0;
    dly_a = '0; dly_b = '0;
    exp_cur = mk(0, 0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_values", dut_pack(), 32'h0008_0000);
    rst = 1'b0;
    chk_en = 1'b1;

    // Pin the trace builder with hand-derived values for dly_a=3, dly_b=2.
    build(3, 2, 1, -1, 16'd0);
    check("pin_len",       exp_q.size(),              7 + GAP);
    check("pin_a_first",   exp_q[0].a,                1);
    check("pin_a_last",    exp_q[2].a,                1);
    check("pin_b_first",   exp_q[3 + GAP].b,          1);
    check("pin_done",      exp_q[5 + GAP].done,       1);
    check("pin_rounds",    exp_q[5 + GAP].rounds,     1);
    check("pin_idle",      exp_q[6 + GAP].g0,         1);

    run_txn(3, 2, 1, -1);
    check("t2_rounds", rounds, 16'd1);
    run_txn(0, 0, 1, -1);
    check("t3_rounds", rounds, 16'd2);
    idle_cycles(2);
    run_txn(2, 2, 3, -1);
    check("t4_rounds", rounds, 16'd5);
    // Abort on the final cycle of PH_B.
    run_txn(2, 3, 1, 4 + GAP);
    check("t5_rounds_kept", rounds, 16'd5);
    run_txn(255, 1, 1, -1);
    check("long_a_rounds", rounds, 16'd6);

    // Reset in the middle of PH_A.
    start = 1'b1; dly_a = 8'd5; dly_b = 8'd1; abort = 1'b0;
    @(posedge clk); #1;
    exp_cur = mk(1, 0, 0, 1, 0, model_rounds);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    model_rounds = '0;
    exp_cur = mk(0, 0, 1, 0, 0, 16'd0);
    check("rst_mid_a", dut_pack(), 32'h0008_0000);
    rst = 1'b0;
    idle_cycles(1);

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(1, 3),
              ($urandom_range(0, 3) == 0) ? -2 : -1);
      idle_cycles($urandom_range(0, 2));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
